// File: rtl/bus_xcvr_pkg.sv
// Shared types and defaults for the bidirectional bus transceiver.
package bus_xcvr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    TURN = 2'd2,
    RX   = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TURN_CYCLES = 1;

endpackage

// File: rtl/tristate_drv.sv
// Registered-enable tri-state pad driver; the only place the inout is assigned,
// so it can be replaced by vendor bufif1 / switch-level cells.
module tristate_drv #(
  parameter int WIDTH = 8
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sample,
  inout  wire  [WIDTH-1:0] io_bus
);

  assign io_bus   = i_en ? i_data : {WIDTH{1'bz}};
  assign o_sample = io_bus;

endmodule

// File: rtl/bidir_bus_xcvr.sv
// Bidirectional bus transceiver: local valid/ready stream to a shared tri-state
// bus, with a high-Z turnaround gap between ownership phases and contention flag.
module bidir_bus_xcvr
  import bus_xcvr_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  inout  wire  [WIDTH-1:0] bus,
  output logic             bus_dir,
  input  logic             peer_drive,
  input  logic             peer_stb,
  output logic             contention,
  output logic             busy
);

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_turn_cnt;
  logic [3:0]       w_turn_cnt_nxt;
  logic             w_tx_ready;
  logic             w_accept;
  logic             w_sample;
  logic             w_contention_nxt;
  logic [WIDTH-1:0] w_bus_in;

  logic [WIDTH-1:0] r_out_q;
  logic             r_bus_dir;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_contention;

  // Next-state, turnaround counter and handshake decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_turn_cnt_nxt   = r_turn_cnt;
    w_tx_ready       = 1'b0;
    w_accept         = 1'b0;
    w_sample         = 1'b0;
    w_contention_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Peer wins a tie with a local request.
        if (peer_drive)    w_state_nxt = RX;
        else if (tx_valid) w_state_nxt = TX;
      end
      TX: begin
        w_tx_ready = !peer_drive;
        if (peer_drive) begin
          w_contention_nxt = 1'b1;
          w_state_nxt      = TURN;
          w_turn_cnt_nxt   = TURN_LOAD;
        end else if (tx_valid) begin
          w_accept = 1'b1;
        end else begin
          w_state_nxt    = TURN;
          w_turn_cnt_nxt = TURN_LOAD;
        end
      end
      TURN: begin
        if (r_turn_cnt <= 4'd1) begin
          w_state_nxt    = IDLE;
          w_turn_cnt_nxt = 4'd0;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - 4'd1;
        end
      end
      RX: begin
        // A strobe coincident with the peer releasing is still captured.
        w_sample = peer_stb;
        if (!peer_drive) begin
          w_state_nxt    = TURN;
          w_turn_cnt_nxt = TURN_LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and turnaround counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_turn_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
    end
  end

  // Bus drive, receive capture and pulse registers; the enable is registered
  // so the pads never follow combinational inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q      <= '0;
      r_bus_dir    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_contention <= 1'b0;
    end else begin
      r_bus_dir    <= w_accept;
      r_rx_valid   <= w_sample;
      r_contention <= w_contention_nxt;
      if (w_accept) r_out_q   <= tx_data;
      if (w_sample) r_rx_data <= w_bus_in;
    end
  end

  tristate_drv #(.WIDTH(WIDTH)) u_drv (
    .i_en     (r_bus_dir),
    .i_data   (r_out_q),
    .o_sample (w_bus_in),
    .io_bus   (bus)
  );

  assign tx_ready   = w_tx_ready;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign bus_dir    = r_bus_dir;
  assign contention = r_contention;
  assign busy       = (r_state != IDLE);

endmodule
